mul_unit: RTL



---
 rtl/mul_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add 16-bit multiplier with start/busy/done handshake.
// Optional feature: define MUL_SIGNED_EN for two's-complement operands
// (magnitude multiply with sign fix-up at completion); default is unsigned.
module mul_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] SR1_IN,
  input  logic [WIDTH-1:0] SR2_IN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic [2:0]       NZP
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, prod;
  logic [WIDTH-1:0]   mplier_q, op_a, op_b, result_q;
  logic [4:0]         cnt_q;
  logic               busy_q, done_q, ovf_q, ovf;
  logic [2:0]         nzp_q, nzp;
`ifdef MUL_SIGNED_EN
  logic               sign_q;
  // Operands enter the engine as magnitudes; the product sign is restored at the end.
  always_comb begin
    op_a = SR1_IN[WIDTH-1] ? -SR1_IN : SR1_IN;
    op_b = SR2_IN[WIDTH-1] ? -SR2_IN : SR2_IN;
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod = sign_q ? -acc_d : acc_d;
    ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    nzp = {prod[WIDTH-1], prod[WIDTH-1:0] == '0, !prod[WIDTH-1] && prod[WIDTH-1:0] != '0};
  end
`else
  // Unsigned product: overflow whenever the upper half is non-zero.
  always_comb begin
    op_a = SR1_IN;
    op_b = SR2_IN;
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod = acc_d;
    ovf = |prod[2*WIDTH-1:WIDTH];
    nzp = {prod[WIDTH-1], prod[WIDTH-1:0] == '0, !prod[WIDTH-1] && prod[WIDTH-1:0] != '0};
  end
`endif
  // Control FSM and datapath; outputs only move on entry to DONE.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      nzp_q    <= 3'b000;
`ifdef MUL_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          mcand_q  <= mcand_q << 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'(WIDTH-1)) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= prod[WIDTH-1:0];
            ovf_q    <= ovf;
            nzp_q    <= nzp;
          end
        end
        default: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, op_a};
            mplier_q <= op_b;
`ifdef MUL_SIGNED_EN
            sign_q   <= SR1_IN[WIDTH-1] ^ SR2_IN[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign NZP      = nzp_q;
endmodule
